// File: rtl/ex_div_pkg.sv
// Shared divider definitions: funct3 encodings, FSM state encoding and iteration count.
package ex_div_pkg;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam int DIV_ITER    = 32;
    localparam int DIV_STATE_W = 2;

    typedef enum logic [DIV_STATE_W-1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == INST_DIV) || (op == INST_REM);
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return (op == INST_REM) || (op == INST_REMU);
    endfunction

    function automatic logic op_is_div_class(input logic [2:0] op);
        return (op == INST_DIV) || (op == INST_DIVU) || op_is_rem(op);
    endfunction

endpackage

// File: rtl/ex_div_abs.sv
// div_abs: combinational conditional two's-complement negate; zero latency, no flow control.
module div_abs #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = neg ? (W'(0) - din) : din;

endmodule

// File: rtl/ex_div.sv
// ex_div: radix-2 restoring divider for DIV/DIVU/REM/REMU; optional DIV_EARLY_OUT_EN exits early when |a| < |b|.
// Latency DATA_W+1 cycles (1 for x/0, signed overflow, early exit); stalls the pipeline through hold_flag_o.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int DATA_W = DIV_ITER,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic [4:0]        rd_addr_i,
    output logic [DATA_W-1:0] result_o,
    output logic [4:0]        rd_addr_o,
    output logic              wen_o,
    output logic              busy_o,
    output logic              hold_flag_o
);

    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    div_state_e        state_q, state_d;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              sgn_dvd_q, sgn_dvs_q;
    logic [DATA_W-1:0] quot_q, rem_q, dvs_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wen_q;

    logic              in_signed, in_rem, accept, div_zero, ovf, early, fast;
    logic [DATA_W-1:0] dvd_mag, dvs_mag, special_res;
    logic [DATA_W:0]   rem_sh, diff;
    logic              take, last;
    logic [DATA_W-1:0] rem_nx, quot_nx, quot_fix, rem_fix;

    assign in_signed = op_is_signed(op_i);
    assign in_rem    = op_is_rem(op_i);
    assign accept    = start_i && !flush_i && (state_q == DIV_IDLE) && op_is_div_class(op_i);

    div_abs #(.W(DATA_W)) u_abs_dvd (.neg(in_signed & dividend_i[DATA_W-1]), .din(dividend_i), .dout(dvd_mag));
    div_abs #(.W(DATA_W)) u_abs_dvs (.neg(in_signed & divisor_i[DATA_W-1]),  .din(divisor_i),  .dout(dvs_mag));

    assign div_zero = (divisor_i == '0);
    assign ovf      = in_signed && (dividend_i == MIN_NEG) && (divisor_i == '1);
`ifdef DIV_EARLY_OUT_EN
    assign early    = !div_zero && (dvd_mag < dvs_mag);
`else
    assign early    = 1'b0;
`endif
    assign fast     = div_zero || ovf || early;

    // Single-cycle outcomes: the raw dividend already carries the right remainder sign.
    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = in_rem ? dividend_i : '1;
        else if (ovf)
            special_res = in_rem ? '0 : MIN_NEG;
        else
            special_res = in_rem ? dividend_i : '0;
    end

    // One restoring step; rem_sh carries an extra bit since 2*rem can exceed DATA_W bits.
    assign rem_sh  = {rem_q, quot_q[DATA_W-1]};
    assign diff    = rem_sh - {1'b0, dvs_q};
    assign take    = !diff[DATA_W];
    assign rem_nx  = take ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    assign quot_nx = {quot_q[DATA_W-2:0], take};
    assign last    = (cnt_q == CNT_W'(1));

    div_abs #(.W(DATA_W)) u_fix_quot (.neg(sgn_dvd_q ^ sgn_dvs_q), .din(quot_nx), .dout(quot_fix));
    div_abs #(.W(DATA_W)) u_fix_rem  (.neg(sgn_dvd_q),             .din(rem_nx),  .dout(rem_fix));

    always_ff @(posedge clk) begin
        if (!rstn)
            state_q <= DIV_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        hold_flag_o = accept || (state_q == DIV_CALC);
        case (state_q)
            DIV_IDLE: if (accept) state_d = fast ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (last)   state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (flush_i)
            state_d = DIV_IDLE;
    end

    // The result is fixed up on the final step so wen_o is registered and lands in DONE.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_q      <= '0;
            rd_q      <= '0;
            sgn_dvd_q <= 1'b0;
            sgn_dvs_q <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            result_o  <= '0;
            rd_addr_o <= '0;
            wen_q     <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            if (flush_i) begin
                cnt_q <= '0;
            end else begin
                case (state_q)
                    DIV_IDLE: begin
                        if (accept) begin
                            op_q      <= op_i;
                            rd_q      <= rd_addr_i;
                            sgn_dvd_q <= in_signed & dividend_i[DATA_W-1];
                            sgn_dvs_q <= in_signed & divisor_i[DATA_W-1];
                            quot_q    <= dvd_mag;
                            rem_q     <= '0;
                            dvs_q     <= dvs_mag;
                            cnt_q     <= CNT_W'(DATA_W);
                            if (fast) begin
                                result_o  <= special_res;
                                rd_addr_o <= rd_addr_i;
                                wen_q     <= 1'b1;
                            end
                        end
                    end
                    DIV_CALC: begin
                        quot_q <= quot_nx;
                        rem_q  <= rem_nx;
                        cnt_q  <= cnt_q - CNT_W'(1);
                        if (last) begin
                            result_o  <= op_is_rem(op_q) ? rem_fix : quot_fix;
                            rd_addr_o <= rd_q;
                            wen_q     <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wen_o  = wen_q && !flush_i;
    assign busy_o = (state_q != DIV_IDLE);

endmodule
